key_debounce: RTL and testbench
===============================

KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 65536, the number of consecutive stable synchronized samples needed to accept a level change (legal range 2..2^20).
REQ-002 SHALL have port clk, input, 1, the single system clock; all logic on its rising edge.
REQ-003 SHALL have port rst, input, 1, a synchronous active-high reset.
REQ-004 SHALL have port count, input, 1, the raw asynchronous push-button level, active-high, possibly bouncing.
REQ-005 SHALL have port cnt, output, 1, the registered debounced button level.
REQ-006 SHALL have port press, output, 1, a registered single-cycle pulse for each accepted press.
REQ-007 SHALL have port s_out, output, 2, the registered FSM state code.
REQ-008 SHALL have port press_count, output, 8, the registered count of accepted presses.

Function
REQ-009 SHALL pass count through a two-flop synchronizer; only the second-flop output (count_s) SHALL drive logic.
REQ-010 SHALL implement the FSM states IDLE=00, PRESS_WAIT=01, PRESSED=10 and RELEASE_WAIT=11, with s_out equal to the current state code.
REQ-011 SHALL hold a timer of ceil(log2(DB_CYCLES)) bits that clears on every state change and increments each cycle in PRESS_WAIT and RELEASE_WAIT.
REQ-012 SHALL, in IDLE, go to PRESS_WAIT if count_s=1 and otherwise stay.
REQ-013 SHALL, in PRESS_WAIT, go to IDLE if count_s=0, go to PRESSED if count_s=1 and timer=DB_CYCLES-1, and otherwise stay.
REQ-014 SHALL, in PRESSED, go to RELEASE_WAIT if count_s=0 and otherwise stay.
REQ-015 SHALL, in RELEASE_WAIT, go to PRESSED if count_s=1 (no pulse), go to IDLE if count_s=0 and timer=DB_CYCLES-1, and otherwise stay.
REQ-016 SHALL drive cnt=1 exactly while the state is PRESSED or RELEASE_WAIT.
REQ-017 SHALL assert press=1 only in the first cycle of PRESSED entered from PRESS_WAIT, never on re-entry from RELEASE_WAIT.
REQ-018 SHALL increment press_count in the same cycle press=1, wrapping 255->0 without saturating.
REQ-019 SHALL produce latency such that, with count held high from before clock edge E, state becomes PRESS_WAIT at edge E+2 and PRESSED (cnt=1, press=1) at edge E+2+DB_CYCLES.
REQ-020 SHALL make a stable release accepted after the same latency: state becomes IDLE and cnt=0 at edge E+2+DB_CYCLES after count falls before edge E.
REQ-021 SHALL treat any glitch shorter than DB_CYCLES synchronized cycles as producing no change in cnt, press or press_count.
REQ-022 SHALL never let the timer exceed DB_CYCLES-1 or wrap.

Reset
REQ-023 SHALL, when rst=1 at a clock edge, clear the synchronizer flops, timer and press_count, set state IDLE, and drive cnt=0, press=0, s_out=00, press_count=0 from that edge.
REQ-024 SHALL make rst take priority over every transition, including a pending press pulse.
REQ-025 SHALL, if rst asserts mid-operation with the button still held after release, run the full debounce again and produce exactly one new press pulse.

Verification (DB_CYCLES=4)
REQ-026 SHALL cover a clean press: count 0->1 before edge 10 and held -> s_out=01 at edge 12, s_out=10, cnt=1, press=1 for one cycle and press_count=1 at edge 16.
REQ-027 SHALL cover a bounce: count high for 2 cycles, low for 1, then high and held -> s_out returns to 00 at least once, exactly one press pulse results, and press_count=1.
REQ-028 SHALL cover a release bounce: from PRESSED, count low for 2 cycles then high -> s_out 10->11->10, cnt stays 1, no press pulse, and press_count unchanged.
REQ-029 SHALL cover a clean release: count 1->0 before edge E and held -> cnt=0 and s_out=00 at edge E+6.
REQ-030 SHALL cover wrap: 256 clean press/release cycles -> press_count=0 afterward and exactly 256 press pulses.
REQ-031 SHALL cover reset mid-PRESS_WAIT with count held: all outputs are 0 the edge after rst; after rst deasserts, press=1 occurs 6 edges after the first edge with rst=0.

Source files
------------

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - push-button debouncer with a press/release FSM, press pulse and press counter
module key_debounce #(
    parameter int DB_CYCLES = 65536
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       count,
    output logic       cnt,
    output logic       press,
    output logic [1:0] s_out,
    output logic [7:0] press_count
);

    localparam int TW = $clog2(DB_CYCLES);
    localparam logic [TW-1:0] T_LAST = TW'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE         = 2'b00,
        PRESS_WAIT   = 2'b01,
        PRESSED      = 2'b10,
        RELEASE_WAIT = 2'b11
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          sync1;
    logic          count_s;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_nxt;
    logic          timer_done;
    logic          press_nxt;

    // Two-flop synchronizer; only count_s feeds the FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1   <= 1'b0;
            count_s <= 1'b0;
        end else begin
            sync1   <= count;
            count_s <= sync1;
        end
    end

    assign timer_done = (timer == T_LAST);

    always_comb begin
        state_nxt = state;
        press_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (count_s) state_nxt = PRESS_WAIT;
            end
            PRESS_WAIT: begin
                if (!count_s) begin
                    state_nxt = IDLE;
                end else if (timer_done) begin
                    state_nxt = PRESSED;
                    press_nxt = 1'b1;
                end
            end
            PRESSED: begin
                if (!count_s) state_nxt = RELEASE_WAIT;
            end
            RELEASE_WAIT: begin
                if (count_s) begin
                    state_nxt = PRESSED;
                end else if (timer_done) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Every state change restarts the stability window, so the timer tops out at T_LAST.
    always_comb begin
        timer_nxt = timer;
        if (state_nxt != state) begin
            timer_nxt = '0;
        end else if (state == PRESS_WAIT || state == RELEASE_WAIT) begin
            timer_nxt = timer + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            timer       <= '0;
            cnt         <= 1'b0;
            press       <= 1'b0;
            press_count <= 8'd0;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
            cnt   <= (state_nxt == PRESSED) || (state_nxt == RELEASE_WAIT);
            press <= press_nxt;
            if (press_nxt) press_count <= press_count + 8'd1;
        end
    end

    assign s_out = state;

endmodule

// File: tb/tb_key_debounce.sv
// tb/tb_key_debounce.sv - self-checking bench for key_debounce with DB_CYCLES=4
module tb_key_debounce;

    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       count = 1'b0;
    logic       cnt;
    logic       press;
    logic [1:0] s_out;
    logic [7:0] press_count;

    key_debounce #(.DB_CYCLES(DB)) dut (
        .clk(clk),
        .rst(rst),
        .count(count),
        .cnt(cnt),
        .press(press),
        .s_out(s_out),
        .press_count(press_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       r;
        logic       c;
        logic       e_cnt;
        logic       e_press;
        logic [1:0] e_s;
        logic [7:0] e_pc;
    } vec_t;

    vec_t tbl[18];

    int checks = 0;
    int passes = 0;

    // Reference: a level flips once DB+1 consecutive synchronized samples disagree with it.
    logic       m_s1, m_s2, m_level, m_press;
    int         m_run;
    logic [7:0] m_pc;

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got cnt=%b press=%b s=%b pc=%0d, expected cnt=%b press=%b s=%b pc=%0d",
                      name, act[11], act[10], act[9:8], act[7:0], exp[11], exp[10], exp[9:8], exp[7:0]);
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic step(input logic c, input logic r, input bit use_model);
        count = c;
        rst   = r;
        @(posedge clk);
        if (r) begin
            m_s1 = 0; m_s2 = 0; m_level = 0; m_run = 0; m_pc = 0; m_press = 0;
        end else begin
            m_press = 0;
            if (m_s2 != m_level) m_run++;
            else m_run = 0;
            if (m_run == DB + 1) begin
                m_level = !m_level;
                m_run = 0;
                if (m_level) begin
                    m_press = 1;
                    m_pc = m_pc + 8'd1;
                end
            end
            m_s2 = m_s1;
            m_s1 = c;
        end
        #1;
        if (use_model)
            check("model", {cnt, press, s_out, press_count},
                  {m_level, m_press, m_level, (m_run > 0), m_pc});
    endtask

    initial begin
        int pulses, idx, pc0;
        bit saw_pw, saw_idle, saw_rw, cnt_low;
        logic val;
        int hold;

        // Clean press then clean release; count rises before row 2's edge, falls before row 10's.
        for (int i = 0; i < 18; i++) begin
            tbl[i].r = (i == 0);
            tbl[i].c = (i >= 2 && i < 10);
            tbl[i].e_cnt = (i >= 8 && i <= 15);
            tbl[i].e_press = (i == 8);
            tbl[i].e_s = (i >= 4 && i <= 7) ? 2'b01 :
                         (i >= 8 && i <= 11) ? 2'b10 :
                         (i >= 12 && i <= 15) ? 2'b11 : 2'b00;
            tbl[i].e_pc = (i >= 8) ? 8'd1 : 8'd0;
        end
        for (int i = 0; i < 18; i++) begin
            step(tbl[i].c, tbl[i].r, 1'b0);
            check($sformatf("table_row%0d", i), {cnt, press, s_out, press_count},
                  {tbl[i].e_cnt, tbl[i].e_press, tbl[i].e_s, tbl[i].e_pc});
        end

        // Press bounce: high 2, low 1, then held.
        pc0 = press_count; pulses = 0; saw_pw = 0; saw_idle = 0;
        for (int i = 0; i < 16; i++) begin
            step((i == 2) ? 1'b0 : 1'b1, 1'b0, 1'b1);
            if (press) pulses++;
            if (s_out == 2'b01) saw_pw = 1;
            if (saw_pw && s_out == 2'b00) saw_idle = 1;
        end
        check_val("bounce_back_to_idle", saw_idle, 1);
        check_val("bounce_pulses", pulses, 1);
        check_val("bounce_press_count", press_count, pc0 + 1);

        // Release bounce: low 2 then high again while pressed.
        pc0 = press_count; pulses = 0; saw_rw = 0; cnt_low = 0;
        for (int i = 0; i < 10; i++) begin
            step((i < 2) ? 1'b0 : 1'b1, 1'b0, 1'b1);
            if (press) pulses++;
            if (!cnt) cnt_low = 1;
            if (s_out == 2'b11) saw_rw = 1;
        end
        check_val("relbounce_saw_rw", saw_rw, 1);
        check_val("relbounce_cnt_held", cnt_low, 0);
        check_val("relbounce_pulses", pulses, 0);
        check_val("relbounce_state", s_out, 2);
        check_val("relbounce_press_count", press_count, pc0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1);

        // Reset while in PRESS_WAIT with the button held, then one fresh press.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1);
        check_val("pre_reset_press_wait", s_out, 1);
        step(1'b1, 1'b1, 1'b1);
        check("reset_outputs", {cnt, press, s_out, press_count}, 12'd0);
        idx = 0; pulses = 0;
        for (int i = 1; i <= 12; i++) begin
            step(1'b1, 1'b0, 1'b1);
            if (press) begin
                pulses++;
                if (idx == 0) idx = i;
            end
        end
        check_val("reset_press_latency", idx, 7);
        check_val("reset_press_pulses", pulses, 1);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1);

        // 256 clean press/release cycles wrap the counter.
        pc0 = press_count; pulses = 0;
        for (int n = 0; n < 256; n++) begin
            for (int i = 0; i < 16; i++) begin
                step((i < 8) ? 1'b1 : 1'b0, 1'b0, 1'b1);
                if (press) pulses++;
            end
        end
        check_val("wrap_pulses", pulses, 256);
        check_val("wrap_press_count", press_count, pc0);

        // Randomized bouncing with occasional reset, checked against the reference.
        val = 0; hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                val  = 1'($urandom_range(0, 1));
                hold = $urandom_range(1, 9);
            end
            hold--;
            step(val, ($urandom_range(0, 299) == 0), 1'b1);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
